// File: rtl/mult_div_unit.sv
// Multicycle signed/unsigned multiply and divide engine for the HI/LO path.
// Shift-add multiply, restoring divide, one step per cycle, Start/Busy/Done handshake.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t             state, stateNext;
  logic [1:0]         opReg;
  logic [WIDTH-1:0]   aReg, bReg, quo, rem;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               signA, signB;

  logic               isDiv, isSigned, divByZero;
  logic [WIDTH:0]     mulSum, remShift, divTrial;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;

  // Op[1] selects divide, Op[0] selects the unsigned variant.
  assign isDiv     = opReg[1];
  assign isSigned  = ~opReg[0];
  assign divByZero = isDiv && (bReg == '0);

  // Multiply adds the multiplicand into the top half, then shifts the accumulator right.
  assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (bReg[0] ? {1'b0, aReg} : '0);
  // The WIDTH+1-bit partial remainder: previous remainder with the next dividend bit appended.
  assign remShift = {rem, aReg[WIDTH-1]};
  assign divTrial = remShift - {1'b0, bReg};

  assign prodFix = (signA ^ signB) ? -acc : acc;
  assign quoFix  = (signA ^ signB) ? -quo : quo;
  assign remFix  = signA ? -rem : rem;

  assign Busy = (state == PREP) || (state == ITER) || (state == FIX);
  assign Done = (state == DONE);

  always_ff @(posedge Clk or negedge Reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    // NOTE: default first so no path leaves stateNext unassigned (no latch).
    stateNext = state;
    case (state)
      IDLE:    if (Start) stateNext = PREP;
      PREP:    stateNext = divByZero ? DONE : ITER;
      ITER:    if (count == CW'(1)) stateNext = FIX;
      FIX:     stateNext = DONE;
      DONE:    stateNext = Start ? PREP : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      opReg   <= '0;
      aReg    <= '0;
      bReg    <= '0;
      acc     <= '0;
      rem     <= '0;
      quo     <= '0;
      count   <= '0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
      DivZero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            opReg   <= Op;
            aReg    <= A;
            bReg    <= B;
            DivZero <= 1'b0;
          end
        end
        PREP: begin
          signA <= isSigned && aReg[WIDTH-1];
          signB <= isSigned && bReg[WIDTH-1];
          if (isSigned && aReg[WIDTH-1]) aReg <= -aReg;
          if (isSigned && bReg[WIDTH-1]) bReg <= -bReg;
          acc   <= '0;
          rem   <= '0;
          quo   <= '0;
          count <= CW'(WIDTH);
          if (divByZero) begin
            Hi      <= aReg;
            Lo      <= '1;
            DivZero <= 1'b1;
          end
        end
        ITER: begin
          count <= count - CW'(1);
          if (isDiv) begin
            aReg <= aReg << 1;
            rem  <= divTrial[WIDTH] ? remShift[WIDTH-1:0] : divTrial[WIDTH-1:0];
            quo  <= {quo[WIDTH-2:0], ~divTrial[WIDTH]};
          end else begin
            acc  <= {mulSum, acc[WIDTH-1:1]};
            bReg <= bReg >> 1;
          end
        end
        FIX: begin
          if (isDiv) begin
            Hi <= remFix;
            Lo <= quoFix;
          end else begin
            Hi <= prodFix[2*WIDTH-1:WIDTH];
            Lo <= prodFix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit at WIDTH 32 and 8.
// Results are predicted with plain 64-bit arithmetic rather than bit-level steps.
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start32, Start8;
  logic [1:0]  Op32, Op8;
  logic [31:0] A32, B32, Hi32, Lo32;
  logic [7:0]  A8, B8, Hi8, Lo8;
  logic        Busy32, Done32, DivZero32, Busy8, Done8, DivZero8;

  int checks = 0;
  int failures = 0;
  bit sel8 = 1'b0;

  always #5 Clk = ~Clk;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .Clk(Clk), .Reset(Reset), .Start(Start32), .Op(Op32), .A(A32), .B(B32),
    .Hi(Hi32), .Lo(Lo32), .Busy(Busy32), .Done(Done32), .DivZero(DivZero32)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Start(Start8), .Op(Op8), .A(A8), .B(B8),
    .Hi(Hi8), .Lo(Lo8), .Busy(Busy8), .Done(Done8), .DivZero(DivZero8)
  );

  wire [63:0] curHi   = sel8 ? {56'b0, Hi8} : {32'b0, Hi32};
  wire [63:0] curLo   = sel8 ? {56'b0, Lo8} : {32'b0, Lo32};
  wire        curBusy = sel8 ? Busy8 : Busy32;
  wire        curDone = sel8 ? Done8 : Done32;
  wire        curDz   = sel8 ? DivZero8 : DivZero32;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact arithmetic on sign-extended operands, then truncated to w bits.
  function automatic void model(input int w, input logic [1:0] op, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] hi,
                                output logic [63:0] lo, output logic dz);
    logic [63:0] mask, up;
    longint sa, sb, sp, q, r;
    mask = (64'd1 << w) - 64'd1;
    sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin
        sp = sa * sb;
        hi = (64'(sp) >> w) & mask;
        lo = 64'(sp) & mask;
      end
      2'd1: begin
        up = a * b;
        hi = (up >> w) & mask;
        lo = up & mask;
      end
      default: begin
        if (b == 0) begin
          dz = 1'b1;
          hi = a;
          lo = mask;
        end else if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          hi = 64'(r) & mask;
          lo = 64'(q) & mask;
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
    endcase
  endfunction

  task automatic driveStart(input logic s, input logic [1:0] op, input logic [63:0] a,
                            input logic [63:0] b);
    Start32 = 1'b0;
    Start8  = 1'b0;
    if (sel8) begin
      Start8 = s; Op8 = op; A8 = a[7:0]; B8 = b[7:0];
    end else begin
      Start32 = s; Op32 = op; A32 = a[31:0]; B32 = b[31:0];
    end
  endtask

  // Waits for Done counting edges after the accepting edge; optional spurious Start at cycle pulseAt.
  task automatic waitDone(input string tag, input int pulseAt, output int n);
    n = 0;
    while (!curDone && n < 200) begin
      @(negedge Clk);
      driveStart(n + 1 == pulseAt, 2'd3, 64'd1, 64'd1);
      @(posedge Clk);
      #1;
      n++;
      check({tag, "_busy_done_excl"}, {63'b0, curBusy & curDone}, 64'd0);
    end
    if (!curDone) check({tag, "_timeout"}, 64'd0, 64'd1);
    driveStart(1'b0, 2'd0, 64'd0, 64'd0);
  endtask

  task automatic runOp(input string tag, input int w, input logic [1:0] op,
                       input logic [63:0] a, input logic [63:0] b, input int pulseAt);
    logic [63:0] eHi, eLo;
    logic eDz;
    int n;
    sel8 = (w == 8);
    model(w, op, a, b, eHi, eLo, eDz);
    @(negedge Clk);
    driveStart(1'b1, op, a, b);
    @(posedge Clk);
    #1;
    driveStart(1'b0, 2'd0, 64'd0, 64'd0);
    check({tag, "_accept_busy"}, {63'b0, curBusy}, 64'd1);
    check({tag, "_accept_dzclr"}, {63'b0, curDz}, 64'd0);
    waitDone(tag, pulseAt, n);
    check({tag, "_latency"}, 64'(n), (op[1] && b == 0) ? 64'd1 : 64'(w + 2));
    check({tag, "_hi"}, curHi, eHi);
    check({tag, "_lo"}, curLo, eLo);
    check({tag, "_dz"}, {63'b0, curDz}, {63'b0, eDz});
    check({tag, "_busy_low"}, {63'b0, curBusy}, 64'd0);
  endtask

  initial begin
    int n;
    logic [63:0] ra, rb;
    logic [1:0] rop;
    int sel;

    Reset = 1'b0;
    Start32 = 1'b0; Op32 = '0; A32 = '0; B32 = '0;
    Start8 = 1'b0;  Op8 = '0;  A8 = '0;  B8 = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_hi", curHi, 64'd0);
    check("rst_lo", curLo, 64'd0);
    check("rst_busy", {63'b0, curBusy}, 64'd0);
    check("rst_done", {63'b0, curDone}, 64'd0);
    check("rst_dz", {63'b0, curDz}, 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(posedge Clk);

    runOp("mult_neg", 32, 2'd0, 64'hFFFFFFFD, 64'd5, 0);
    runOp("multu_max", 32, 2'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, 0);
    runOp("mult_m1", 32, 2'd0, 64'hFFFFFFFF, 64'hFFFFFFFF, 0);
    runOp("div_neg", 32, 2'd2, 64'hFFFFFFF9, 64'd2, 0);
    runOp("div_wrap", 32, 2'd2, 64'h80000000, 64'hFFFFFFFF, 0);
    runOp("divu_zero", 32, 2'd3, 64'd100, 64'd0, 0);
    repeat (3) @(posedge Clk);
    #1;
    check("dz_held", {63'b0, curDz}, 64'd1);
    runOp("div_zero_s", 32, 2'd2, 64'hFFFFFFF9, 64'd0, 0);
    runOp("mult_ignore_start", 32, 2'd0, 64'h12345678, 64'hFEDCBA98, 10);

    // Start held high: the second operation is taken only in DONE.
    sel8 = 1'b0;
    @(negedge Clk);
    driveStart(1'b1, 2'd1, 64'd3, 64'd4);
    @(posedge Clk);
    #1;
    Op32 = 2'd3; A32 = 32'd7; B32 = 32'd6;
    n = 0;
    while (!Done32 && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("hold_first_latency", 64'(n), 64'd34);
    check("hold_first_lo", curLo, 64'd12);
    check("hold_first_hi", curHi, 64'd0);
    @(posedge Clk);
    #1;
    Start32 = 1'b0;
    check("hold_second_busy", {63'b0, curBusy}, 64'd1);
    n = 0;
    while (!Done32 && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("hold_second_latency", 64'(n), 64'd34);
    check("hold_second_lo", curLo, 64'd1);
    check("hold_second_hi", curHi, 64'd1);

    // Reset in the middle of an iteration.
    runOp("pre_reset", 32, 2'd1, 64'hDEADBEEF, 64'h00010001, 0);
    @(negedge Clk);
    driveStart(1'b1, 2'd0, 64'h11111111, 64'h22222222);
    @(posedge Clk);
    #1;
    driveStart(1'b0, 2'd0, 64'd0, 64'd0);
    repeat (15) @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    check("midrst_hi", curHi, 64'd0);
    check("midrst_lo", curLo, 64'd0);
    check("midrst_busy", {63'b0, curBusy}, 64'd0);
    check("midrst_done", {63'b0, curDone}, 64'd0);
    check("midrst_dz", {63'b0, curDz}, 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("post_rst_idle", {62'b0, curBusy, curDone}, 64'd0);

    runOp("w8_mult_neg", 8, 2'd0, 64'hFD, 64'd5, 0);
    runOp("w8_mult_m1", 8, 2'd0, 64'hFF, 64'hFF, 0);
    runOp("w8_div_neg", 8, 2'd2, 64'hF9, 64'd2, 0);
    runOp("w8_div_wrap", 8, 2'd2, 64'h80, 64'hFF, 0);
    runOp("w8_div_rem_neg", 8, 2'd2, 64'h07, 64'hFE, 0);
    runOp("w8_divu_zero", 8, 2'd3, 64'd100, 64'd0, 0);

    for (int i = 0; i < 100; i++) begin
      sel = (i % 2 == 0) ? 32 : 8;
      rop = 2'($urandom_range(0, 3));
      ra = {32'b0, $urandom};
      rb = {32'b0, $urandom};
      case ($urandom_range(0, 9))
        0: rb = 64'd0;
        1: rb = 64'hFFFFFFFF;
        2: rb = 64'd1;
        3: ra = 64'h80000000;
        default: ;
      endcase
      if (sel == 8) begin
        ra = ra & 64'hFF;
        rb = rb & 64'hFF;
        if (ra == 64'h80000000 >> 24) ra = 64'h80;
      end
      repeat ($urandom_range(0, 2)) @(posedge Clk);
      runOp(sel == 8 ? "rand8" : "rand32", sel, rop, ra, rb, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
